// File: rtl/hex_string_formatter.sv
// Formats a 32-bit word plus an 8-char ASCII label into a 16-char display string, one hex digit per cycle.
// Build macro HEX_STRING_FORMATTER_ZERO_BLANK_EN: leading zero digits (except the last) render as spaces.
module hex_string_formatter #(
  parameter bit          UPPERCASE = 1'b1,
  parameter logic [23:0] MIN_GAP   = 24'd0
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  in_value,
  input  logic [63:0]  in_label,
  output logic [127:0] str_out,
  output logic         str_valid,
  output logic         busy
);

  localparam logic [127:0] ALL_SPACES = {16{8'h20}};

  typedef enum logic [1:0] {IDLE, CONVERT, COMMIT, GAP} state_t;

  state_t       state_q, state_d;
  logic [2:0]   nib_cnt_q;
  logic [23:0]  gap_cnt_q;
  logic [31:0]  shift_q;
  logic [63:0]  label_q;
  logic [55:0]  hex_q;
  logic         accept;
  logic         last_nib;
  logic [3:0]   nib;
  logic [7:0]   hex_char;
  logic [7:0]   out_char;

  assign accept   = in_valid && in_ready;
  assign nib      = shift_q[31:28];
  assign last_nib = (state_q == CONVERT) && (nib_cnt_q == 3'd7);

  always_comb begin
    hex_char = 8'h30 + {4'h0, nib};
    if (nib >= 4'd10) begin
      // 8'h37 + 10 = 'A', 8'h57 + 10 = 'a'
      hex_char = (UPPERCASE ? 8'h37 : 8'h57) + {4'h0, nib};
    end
  end

`ifdef HEX_STRING_FORMATTER_ZERO_BLANK_EN
  logic blank_q;

  // Char 15 is always a digit so a zero word still shows "0".
  assign out_char = (blank_q && (nib == 4'd0) && (nib_cnt_q != 3'd7)) ? 8'h20 : hex_char;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      blank_q <= 1'b1;
    end else if (accept) begin
      blank_q <= 1'b1;
    end else if ((state_q == CONVERT) && (nib != 4'd0)) begin
      blank_q <= 1'b0;
    end
  end
`else
  assign out_char = hex_char;
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    busy     = 1'b1;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_d = CONVERT;
      end
      CONVERT: if (nib_cnt_q == 3'd7) state_d = COMMIT;
      COMMIT:  state_d = (MIN_GAP == 24'd0) ? IDLE : GAP;
      GAP:     if (gap_cnt_q <= 24'd1) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The whole string is written on the edge that closes the last digit, so the
  // COMMIT cycle already presents the new line together with the str_valid pulse.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      nib_cnt_q <= 3'd0;
      gap_cnt_q <= 24'd0;
      str_out   <= ALL_SPACES;
      str_valid <= 1'b0;
    end else begin
      str_valid <= 1'b0;
      if (accept) begin
        nib_cnt_q <= 3'd0;
      end else if (state_q == CONVERT) begin
        nib_cnt_q <= nib_cnt_q + 3'd1;
      end
      if (state_q == COMMIT) begin
        gap_cnt_q <= MIN_GAP;
      end else if (state_q == GAP) begin
        gap_cnt_q <= gap_cnt_q - 24'd1;
      end
      if (last_nib) begin
        str_out   <= {label_q, hex_q, out_char};
        str_valid <= 1'b1;
      end
    end
  end

  // NOTE: the shadow registers carry no reset: each is fully rewritten before str_out reads it.
  always_ff @(posedge clk) begin
    if (accept) begin
      shift_q <= in_value;
      label_q <= in_label;
    end else if (state_q == CONVERT) begin
      shift_q <= {shift_q[27:0], 4'h0};
      hex_q   <= {hex_q[47:0], out_char};
    end
  end

endmodule

// File: doc/hex_string_formatter.md
Name: hex_string_formatter

Overview:
- Converts a 32-bit word plus an 8-character ASCII label into a 16-character display string (128-bit bus) for the text path that drives the screen.
- Sits directly upstream of the string-to-byte serialiser. It replaces the ad-hoc packing of the ALU/register decoder output with a handshaked, glitch-free formatter.
- The string bus changes atomically, once per conversion, so the text engine never renders a half-updated line.

Parameters:
- UPPERCASE, 1, 1 selects hex digits 'A'-'F'; 0 selects 'a'-'f'.
- MIN_GAP, 0, number of idle cycles enforced after each commit before the next word is accepted. Used to rate-limit display updates. Width is 24 bits; 0 means back-to-back.

Ports:
- clk  input  1  system clock
- resetn  input  1  asynchronous active-low reset
- in_valid  input  1  request to format in_value/in_label
- in_ready  output  1  block can accept a request this cycle
- in_value  input  32  word to render as 8 hex digits
- in_label  input  64  8 ASCII chars; char 0 at [63:56]
- str_out  output  128  16-char string; char 0 at [127:120], chars 0-7 = label, chars 8-15 = hex MSB-first
- str_valid  output  1  one-cycle pulse when str_out has just been updated
- busy  output  1  high while a conversion or gap is in progress

Behaviour:
- Reset (resetn low, asynchronous; release synchronous to clk):
  - str_out = 16 x 8'h20 (all spaces)
  - str_valid = 0, busy = 0, in_ready = 1
  - FSM goes to IDLE; nibble counter = 0; gap counter = 0
- FSM states: IDLE, CONVERT, COMMIT, GAP.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready at cycle N: latch in_value into a shift register and in_label into a shadow string. Go to CONVERT.
  - in_value/in_label changes after acceptance are ignored.
- CONVERT (cycles N+1..N+8):
  - Each cycle, take the top nibble of the shift register, map it to ASCII, and write it into shadow char 8+k (k = 0..7). Then shift left by 4.
  - Nibble map: 0-9 -> 8'h30+n; 10-15 -> 8'h41+(n-10) when UPPERCASE, else 8'h61+(n-10).
  - After k = 7, go to COMMIT. in_ready = 0, busy = 1.
- COMMIT (cycle N+9):
  - str_out <= shadow (all 128 bits in one edge); str_valid = 1 for this cycle only.
  - If MIN_GAP == 0, go to IDLE; otherwise load the gap counter with MIN_GAP and go to GAP.
  - in_ready = 0.
- GAP:
  - Decrement the counter each cycle; go to IDLE when it reaches 1. busy = 1, in_ready = 0.
- Latency: the request accepted at N produces the str_out update and str_valid pulse at N+9. Minimum request spacing is 10 + MIN_GAP cycles.
- str_out holds its value between commits. It is never partially updated.
- in_valid while in_ready = 0: no effect, nothing is queued. The requester must hold in_valid until the handshake.
- Reset mid-CONVERT or mid-GAP: conversion is abandoned, str_out returns to all spaces, and no str_valid pulse occurs.
- in_label bytes are passed through unmodified, including non-printable codes.
- busy = (state != IDLE).

Optional Feature:
- Macro: HEX_STRING_FORMATTER_ZERO_BLANK_EN
- Defined: leading zero digits in chars 8-14 are emitted as 8'h20 until the first non-zero nibble. Char 15 is always a digit, so value 0 renders as seven spaces then "0". A blank flag is set at acceptance and cleared on the first non-zero nibble.
- Undefined: all 8 digits are always emitted, with leading zeros. Timing is identical in both builds.

Test Plan:
- Reset release, no request -> str_out = 128'h2020...20 (16 spaces), in_ready = 1, str_valid never pulses over 50 cycles.
- in_value = 32'hDEADBEEF, in_label = "PC=     ", UPPERCASE = 1, accepted at N -> at N+9 str_out = "PC=     DEADBEEF", str_valid is high for exactly 1 cycle, and str_out is unchanged at N+1..N+8.
- UPPERCASE = 0, in_value = 32'h00A1F00C -> hex field "00a1f00c". With ZERO_BLANK_EN -> "  a1f00c". Value 0 with ZERO_BLANK_EN -> "       0".
- MIN_GAP = 5, in_valid held high with values 1 then 2 -> second accept at N+15, second str_valid at N+24; in_ready = 0 from N+1 through N+14.
- Assert resetn low at N+4 mid-conversion of 32'h12345678 -> str_out immediately all spaces, no str_valid. A request after release completes normally with the correct string.
- in_value changed to 32'hFFFFFFFF at N+2 after accepting 32'h00000001 -> committed hex field = "00000001".
